// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Programmable multi-LED blink sequencer (clk_slow domain). Walks a table of
//   {mask, on-time, off-time} entries, driving N_LED outputs, with one-shot or
//   looped playback, start/stop control and live table writes.
// Ports
//   clk_slow, i_RST (async, active-high)
//   i_START / i_STOP / i_LOOP      playback control
//   i_CFG_WE/ADDR/MASK/ON/OFF      table write port
//   o_LED   registered LED drive
//   o_BUSY  high while in ON/OFF
//   o_DONE  one-cycle pulse on normal completion
//   o_STEP  current step (0 in IDLE)
module led_pattern_sequencer #(
  parameter int N_LED       = 4,
  parameter int N_STEP      = 4,
  parameter int STEP_W      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_ON  = 2,
  parameter int DEFAULT_OFF = 3
) (
  input  logic              clk_slow,
  input  logic              i_RST,
  input  logic              i_START,
  input  logic              i_STOP,
  input  logic              i_LOOP,
  input  logic              i_CFG_WE,
  input  logic [STEP_W-1:0] i_CFG_ADDR,
  input  logic [N_LED-1:0]  i_CFG_MASK,
  input  logic [CNT_W-1:0]  i_CFG_ON,
  input  logic [CNT_W-1:0]  i_CFG_OFF,
  output logic [N_LED-1:0]  o_LED,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic [STEP_W-1:0] o_STEP
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  typedef struct packed {
    logic [N_LED-1:0] mask;
    logic [CNT_W-1:0] on_t;
    logic [CNT_W-1:0] off_t;
  } entry_t;

  localparam logic [STEP_W-1:0] LAST = STEP_W'(N_STEP - 1);

  function automatic entry_t dflt_entry(input int i);
    entry_t e;
    e.mask  = N_LED'(1) << (i % N_LED);
    e.on_t  = CNT_W'(DEFAULT_ON);
    e.off_t = CNT_W'(DEFAULT_OFF);
    return e;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  off_cur_q, off_cur_d;  // off-time latched at step entry
  logic [STEP_W-1:0] step_q, step_d;
  logic [N_LED-1:0]  led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  entry_t            tbl_q [N_STEP];
  entry_t            tbl_d [N_STEP];

  logic              enter, eos, go_idle;
  logic [STEP_W-1:0] enter_step;
  entry_t            ent;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_cur_d  = off_cur_q;
    step_d     = step_q;
    led_d      = led_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    enter      = 1'b0;
    eos        = 1'b0;
    go_idle    = 1'b0;
    enter_step = step_q + STEP_W'(1);  // wraps LAST -> 0 for looping
    ent        = '0;
    for (int i = 0; i < N_STEP; i++) tbl_d[i] = tbl_q[i];
    if (i_CFG_WE) tbl_d[i_CFG_ADDR] = {i_CFG_MASK, i_CFG_ON, i_CFG_OFF};

    case (state_q)
      S_IDLE: if (i_START && !i_STOP) begin
        enter      = 1'b1;
        enter_step = '0;
      end
      S_ON: begin
        if (i_STOP)             go_idle = 1'b1;
        else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
        else if (off_cur_q != '0) begin
          state_d = S_OFF;
          cnt_d   = off_cur_q - CNT_W'(1);
          led_d   = '0;
        end
        else                    eos = 1'b1;
      end
      S_OFF: begin
        if (i_STOP)             go_idle = 1'b1;
        else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
        else                    eos = 1'b1;
      end
      default:                  go_idle = 1'b1;
    endcase

    if (eos) begin
      if (step_q != LAST || i_LOOP) enter = 1'b1;
      else begin
        go_idle = 1'b1;
        done_d  = 1'b1;
      end
    end

    if (go_idle) begin
      state_d = S_IDLE;
      led_d   = '0;
      busy_d  = 1'b0;
      step_d  = '0;
      cnt_d   = '0;
    end

    // Table is read pre-edge, so a write landing on the entry edge is not seen.
    if (enter) begin
      ent       = tbl_q[enter_step];
      state_d   = S_ON;
      step_d    = enter_step;
      led_d     = ent.mask;
      busy_d    = 1'b1;
      cnt_d     = (ent.on_t == '0) ? '0 : ent.on_t - CNT_W'(1);
      off_cur_d = ent.off_t;
    end
  end

  always_ff @(posedge clk_slow or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      off_cur_q <= '0;
      step_q    <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < N_STEP; i++) tbl_q[i] <= dflt_entry(i);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_cur_q <= off_cur_d;
      step_q    <= step_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int i = 0; i < N_STEP; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  assign o_LED  = led_q;
  assign o_BUSY = busy_q;
  assign o_DONE = done_q;
  assign o_STEP = step_q;

endmodule
